// File: rtl/pipe_adder_pkg.sv
// pipe_adder_pkg: shared types and elaboration helpers for the pipelined adder.
package pipe_adder_pkg;

    // Per-stage bookkeeping: beat valid plus the carry handed to the next slice.
    typedef struct packed {
        logic vld;
        logic carry;
    } stage_rec_t;

    function automatic int chunk_width(input int width, input int stages);
        return width / stages;
    endfunction

    function automatic bit cfg_ok(input int width, input int stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/pipe_adder_slice.sv
// adder_slice: CW-bit adder chunk with registered sum and carry, advanced by en.
// CLR marks the slice whose registers drive block outputs and must read 0 after reset.
module adder_slice
    import pipe_adder_pkg::*;
#(
    parameter int CW  = 8,
    parameter bit CLR = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          ci,
    output logic [CW-1:0] sum_q,
    output logic          co_q
);

    logic [CW:0]   res;
    logic [CW-1:0] sum_d;
    logic          co_d;

    always_comb begin
        res   = {1'b0, a} + {1'b0, b} + {{CW{1'b0}}, ci};
        sum_d = sum_q;
        co_d  = co_q;
        if (en) begin
            sum_d = res[CW-1:0];
            co_d  = res[CW];
        end
    end

    always_ff @(posedge clk) begin
        sum_q <= sum_d;
        co_q  <= co_d;
        if (CLR && rst) begin
            sum_q <= '0;
            co_q  <= 1'b0;
        end
    end

endmodule

// File: rtl/pipe_adder.sv
// pipe_adder: STAGES-deep carry-sliced adder with valid/ready on both sides.
// Define PIPE_ADDER_SUB_EN to add the sub port (a - b when sub=1, cin=0).
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef PIPE_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = chunk_width(WIDTH, STAGES);

    if (!cfg_ok(WIDTH, STAGES)) begin : g_bad_cfg
        $error("pipe_adder: WIDTH must be a multiple of STAGES, 1 <= STAGES <= WIDTH");
    end

    logic                         adv;
    logic [STAGES-1:0]            vld_q, vld_d;
    stage_rec_t [STAGES-1:0]      stg;
    logic [STAGES-1:0]            carry_s;
    logic [STAGES-1:0][CW-1:0]    a_sk, b_sk, sum_s, sum_out;
    logic [WIDTH-1:0]             b_eff;
    logic                         cin_eff;
    logic [1:0]                   msb_q, msb_d;

    // Subtract folds into the operand before skewing, so the inverted b
    // and adjusted carry ride along with the beat.
`ifdef PIPE_ADDER_SUB_EN
    assign b_eff   = sub ? ~b : b;
    assign cin_eff = cin ^ sub;
`else
    assign b_eff   = b;
    assign cin_eff = cin;
`endif

    assign out_valid = stg[STAGES-1].vld;
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv || rst;

    always_comb begin
        for (int i = 0; i < STAGES; i++) begin
            stg[i].vld   = vld_q[i];
            stg[i].carry = carry_s[i];
        end
    end

    always_comb begin
        vld_d = vld_q;
        if (adv) begin
            vld_d[0] = in_valid;
            for (int i = 1; i < STAGES; i++) vld_d[i] = stg[i-1].vld;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) vld_q <= '0;
        else     vld_q <= vld_d;
    end

    genvar k;
    for (k = 0; k < STAGES; k++) begin : g_slice
        logic ci;

        if (k == 0) begin : g_head
            assign a_sk[k] = a[CW-1:0];
            assign b_sk[k] = b_eff[CW-1:0];
            assign ci      = cin_eff;
        end else begin : g_skew
            logic [k-1:0][CW-1:0] as_q, as_d, bs_q, bs_d;

            always_comb begin
                as_d = as_q;
                bs_d = bs_q;
                if (adv) begin
                    as_d[0] = a[k*CW +: CW];
                    bs_d[0] = b_eff[k*CW +: CW];
                    for (int i = 1; i < k; i++) begin
                        as_d[i] = as_q[i-1];
                        bs_d[i] = bs_q[i-1];
                    end
                end
            end

            always_ff @(posedge clk) begin
                as_q <= as_d;
                bs_q <= bs_d;
            end

            assign a_sk[k] = as_q[k-1];
            assign b_sk[k] = bs_q[k-1];
            assign ci      = stg[k-1].carry;
        end

        adder_slice #(
            .CW  (CW),
            .CLR (k == STAGES - 1)
        ) u_slice (
            .clk   (clk),
            .rst   (rst),
            .en    (adv),
            .a     (a_sk[k]),
            .b     (b_sk[k]),
            .ci    (ci),
            .sum_q (sum_s[k]),
            .co_q  (carry_s[k])
        );

        if (k == STAGES - 1) begin : g_nodeskew
            assign sum_out[k] = sum_s[k];
        end else begin : g_deskew
            localparam int D = STAGES - 1 - k;
            logic [D-1:0][CW-1:0] ds_q, ds_d;

            always_comb begin
                ds_d = ds_q;
                if (adv) begin
                    ds_d[0] = sum_s[k];
                    for (int i = 1; i < D; i++) ds_d[i] = ds_q[i-1];
                end
            end

            // Only the element feeding the sum port needs a reset value.
            always_ff @(posedge clk) begin
                ds_q <= ds_d;
                if (rst) ds_q[D-1] <= '0;
            end

            assign sum_out[k] = ds_q[D-1];
        end
    end

    // Sign bits of the top chunk travel with the last slice; carry into the
    // MSB is recovered as a ^ b ^ sum at that bit.
    always_comb begin
        msb_d = msb_q;
        if (adv) msb_d = {a_sk[STAGES-1][CW-1], b_sk[STAGES-1][CW-1]};
    end

    always_ff @(posedge clk) begin
        if (rst) msb_q <= '0;
        else     msb_q <= msb_d;
    end

    assign sum  = sum_out;
    assign cout = stg[STAGES-1].carry;
    assign ovf  = cout ^ msb_q[1] ^ msb_q[0] ^ sum[WIDTH-1];

endmodule
